// File: rtl/fft_peak_detect.sv
// Streaming FFT power detector: squares each result bin through a two-stage
// pipeline and reports the strongest bin of the searched half-spectrum per frame.
module fft_peak_detect #(
  parameter int unsigned N_POINTS    = 128,
  parameter int unsigned SEARCH_BINS = 64,
  parameter int unsigned SKIP_DC     = 1,
  localparam int unsigned BIN_W      = $clog2(N_POINTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             res_valid,
  input  logic [7:0]       res_rel,
  input  logic [7:0]       res_img,
  output logic             mag_valid,
  output logic [15:0]      mag_out,
  output logic [BIN_W-1:0] mag_bin,
  output logic             peak_valid,
  output logic [BIN_W-1:0] peak_bin,
  output logic [15:0]      peak_mag,
  output logic             busy
);

  localparam int unsigned SQ_W  = 15;
  localparam int unsigned MAG_W = 16;
  localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(N_POINTS - 1);
  localparam logic [BIN_W:0]   SEARCH_LIM = (BIN_W + 1)'(SEARCH_BINS);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t state_q, state_d;

  logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d;
  logic             bins_done_q, bins_done_d;
  logic [MAG_W-1:0] run_max_q, run_max_d;
  logic [BIN_W-1:0] run_idx_q, run_idx_d;
  logic             have_cand_q, have_cand_d;

  logic             s1_valid_q, s1_valid_d;
  logic [BIN_W-1:0] s1_bin_q, s1_bin_d;
  logic [SQ_W-1:0]  sq_re_q, sq_re_d;
  logic [SQ_W-1:0]  sq_im_q, sq_im_d;
  logic             mag_live_q, mag_live_d;

  logic             mag_valid_d;
  logic [MAG_W-1:0] mag_out_d;
  logic [BIN_W-1:0] mag_bin_d;
  logic             peak_valid_d;
  logic [BIN_W-1:0] peak_bin_d;
  logic [MAG_W-1:0] peak_mag_d;
  logic             busy_d;

  logic signed [7:0]  re_s_c, im_s_c;
  logic signed [15:0] re_sq_c, im_sq_c;
  logic [MAG_W-1:0]   sum_c;
  logic               take_c;
  logic [BIN_W-1:0]   in_bin_c;
  logic               compare_c, cand_c, better_c, last_c;
  logic [MAG_W-1:0]   max_nxt_c;
  logic [BIN_W-1:0]   idx_nxt_c;

  // Input acceptance: a new frame_start always claims the current beat as bin 0
  assign take_c   = res_valid & (frame_start | ((state_q == ACCUM) & ~bins_done_q));
  assign in_bin_c = frame_start ? '0 : bin_cnt_q;

  assign re_s_c  = signed'(res_rel);
  assign im_s_c  = signed'(res_img);
  assign re_sq_c = 16'(re_s_c) * 16'(re_s_c);
  assign im_sq_c = 16'(im_s_c) * 16'(im_s_c);
  assign sum_c   = MAG_W'(sq_re_q) + MAG_W'(sq_im_q);

  // Only stage-2 results of the live frame are compared; a restart cycle compares nothing
  assign compare_c = (state_q == ACCUM) & ~frame_start & mag_valid & mag_live_q;
  assign cand_c    = compare_c & ({1'b0, mag_bin} < SEARCH_LIM)
                   & ~((SKIP_DC != 0) & (mag_bin == '0));
  // First candidate seeds the search so an all-zero frame reports the first candidate bin
  assign better_c  = cand_c & (~have_cand_q | (mag_out > run_max_q));
  assign max_nxt_c = better_c ? mag_out : run_max_q;
  assign idx_nxt_c = better_c ? mag_bin : run_idx_q;
  assign last_c    = compare_c & (mag_bin == LAST_BIN);

  always_comb begin
    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    bins_done_d  = bins_done_q;
    run_max_d    = run_max_q;
    run_idx_d    = run_idx_q;
    have_cand_d  = have_cand_q;
    s1_valid_d   = take_c;
    s1_bin_d     = s1_bin_q;
    sq_re_d      = sq_re_q;
    sq_im_d      = sq_im_q;
    mag_valid_d  = s1_valid_q;
    mag_live_d   = s1_valid_q & ~frame_start;
    mag_out_d    = mag_out;
    mag_bin_d    = mag_bin;
    peak_valid_d = 1'b0;
    peak_bin_d   = peak_bin;
    peak_mag_d   = peak_mag;

    if (take_c) begin
      s1_bin_d = in_bin_c;
      sq_re_d  = SQ_W'(re_sq_c);
      sq_im_d  = SQ_W'(im_sq_c);
    end
    if (s1_valid_q) begin
      mag_out_d = sum_c;
      mag_bin_d = s1_bin_q;
    end

    case (state_q)
      ACCUM: begin
        if (take_c) begin
          bin_cnt_d = bin_cnt_q + BIN_W'(1);
          if (bin_cnt_q == LAST_BIN) bins_done_d = 1'b1;
        end
        if (cand_c) have_cand_d = 1'b1;
        run_max_d = max_nxt_c;
        run_idx_d = idx_nxt_c;
        if (last_c) begin
          state_d      = REPORT;
          peak_valid_d = 1'b1;
          peak_bin_d   = idx_nxt_c;
          peak_mag_d   = max_nxt_c;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = state_q;
    endcase

    // Frame start wins over everything else and restarts the search from scratch
    if (frame_start) begin
      state_d      = ACCUM;
      bin_cnt_d    = take_c ? BIN_W'(1) : '0;
      bins_done_d  = 1'b0;
      run_max_d    = '0;
      run_idx_d    = '0;
      have_cand_d  = 1'b0;
      peak_valid_d = 1'b0;
      peak_bin_d   = peak_bin;
      peak_mag_d   = peak_mag;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt_q   <= '0;
      bins_done_q <= 1'b0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      have_cand_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_bin_q    <= '0;
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      mag_live_q  <= 1'b0;
      mag_valid   <= 1'b0;
      mag_out     <= '0;
      mag_bin     <= '0;
      peak_valid  <= 1'b0;
      peak_bin    <= '0;
      peak_mag    <= '0;
      busy        <= 1'b0;
    end else begin
      bin_cnt_q   <= bin_cnt_d;
      bins_done_q <= bins_done_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      have_cand_q <= have_cand_d;
      s1_valid_q  <= s1_valid_d;
      s1_bin_q    <= s1_bin_d;
      sq_re_q     <= sq_re_d;
      sq_im_q     <= sq_im_d;
      mag_live_q  <= mag_live_d;
      mag_valid   <= mag_valid_d;
      mag_out     <= mag_out_d;
      mag_bin     <= mag_bin_d;
      peak_valid  <= peak_valid_d;
      peak_bin    <= peak_bin_d;
      peak_mag    <= peak_mag_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: directed spectra from a table, abort/reset sequences,
// and random frames checked against an argmax-over-power reference.
module tb_fft_peak_detect;

  localparam int NP   = 128;
  localparam int SB   = 64;
  localparam int SKIP = 1;

  logic       clk = 1'b0;
  logic       rst, frame_start, res_valid;
  logic [7:0] res_rel, res_img;
  logic       mag_valid, peak_valid, busy;
  logic [15:0] mag_out, peak_mag;
  logic [6:0] mag_bin, peak_bin;

  fft_peak_detect #(.N_POINTS(NP), .SEARCH_BINS(SB), .SKIP_DC(SKIP)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .res_valid(res_valid),
    .res_rel(res_rel), .res_img(res_img), .mag_valid(mag_valid), .mag_out(mag_out),
    .mag_bin(mag_bin), .peak_valid(peak_valid), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int bin; int mag; } ev_t;
  ev_t mq[$];
  ev_t pq[$];

  // Output recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (mag_valid === 1'b1)  mq.push_back('{cyc, int'(mag_bin), int'(mag_out)});
    if (peak_valid === 1'b1) pq.push_back('{cyc, int'(peak_bin), int'(peak_mag)});
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int fr_re[NP];
  int fr_im[NP];
  int drv_cyc[NP];
  int busy_bad;

  function automatic int pwr(input int i);
    return fr_re[i] * fr_re[i] + fr_im[i] * fr_im[i];
  endfunction

  function automatic void clear_frame();
    for (int i = 0; i < NP; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endfunction

  // Reference: strongest candidate bin, lowest index on ties
  task automatic model_peak(output int pb, output int pm);
    pb = -1;
    pm = 0;
    for (int i = 0; i < SB; i++) begin
      if (SKIP != 0 && i == 0) continue;
      if (pb < 0 || pwr(i) > pm) begin
        pb = i;
        pm = pwr(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap 0 selects a random spacing of 1..3 cycles per bin
  task automatic drive_frame(input int gap, input int nbins, input int extra,
                             input bit overlap, input int drain);
    int g;
    busy_bad    = 0;
    frame_start = 1'b1;
    if (overlap) begin
      res_valid  = 1'b1;
      res_rel    = 8'(fr_re[0]);
      res_img    = 8'(fr_im[0]);
      drv_cyc[0] = cyc;
    end
    tick();
    frame_start = 1'b0;
    res_valid   = 1'b0;
    for (int i = (overlap ? 1 : 0); i < nbins; i++) begin
      if (busy !== 1'b1) busy_bad++;
      res_valid  = 1'b1;
      res_rel    = 8'(fr_re[i]);
      res_img    = 8'(fr_im[i]);
      drv_cyc[i] = cyc;
      tick();
      res_valid = 1'b0;
      g = (gap == 0) ? int'($urandom_range(3, 1)) : gap;
      for (int j = 1; j < g; j++) begin
        if (i < nbins - 1 && busy !== 1'b1) busy_bad++;
        tick();
      end
    end
    for (int e = 0; e < extra; e++) begin
      res_valid = 1'b1;
      res_rel   = 8'($urandom_range(255));
      res_img   = 8'($urandom_range(255));
      tick();
    end
    res_valid = 1'b0;
    repeat (drain) tick();
  endtask

  task automatic check_frame(input string name, input int eb, input int em);
    int bad = 0;
    chk({name, "_mag_count"}, mq.size(), NP);
    for (int k = 0; k < mq.size() && k < NP; k++)
      if (mq[k].bin != k || mq[k].mag != pwr(k) || mq[k].cyc != drv_cyc[k] + 2) bad++;
    chk({name, "_mag_stream_errs"}, bad, 0);
    chk({name, "_peak_count"}, pq.size(), 1);
    if (pq.size() > 0) begin
      chk({name, "_peak_cycle"}, pq[0].cyc, drv_cyc[NP-1] + 3);
      chk({name, "_peak_bin"}, pq[0].bin, eb);
      chk({name, "_peak_mag"}, pq[0].mag, em);
    end
    chk({name, "_busy_gaps"}, busy_bad, 0);
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_peak_bin_held"}, int'(peak_bin), eb);
    chk({name, "_peak_mag_held"}, int'(peak_mag), em);
  endtask

  typedef struct {
    string name;
    int b0, r0, i0, b1, r1, i1, b2, r2, i2;
    int gap, extra, exp_bin, exp_mag;
  } vec_t;
  vec_t vt[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int pb, pm;

    vt[0] = '{"tone",      5, 100, -50,   -1, 0, 0,        -1, 0, 0,        1, 3, 5, 12500};
    vt[1] = '{"dc_mirror", 0, 127, 127,   100, -128, -128, 10, 3, 4,        1, 0, 10, 25};
    vt[2] = '{"tie_full",  20, -128, -128, 30, -128, -128, -1, 0, 0,        1, 0, 20, 32768};
    vt[3] = '{"gapped",    5, 100, -50,   -1, 0, 0,        -1, 0, 0,        3, 0, 5, 12500};
    vt[4] = '{"all_zero",  -1, 0, 0,      -1, 0, 0,        -1, 0, 0,        1, 0, 1, 0};
    vt[5] = '{"edge_63",   63, 1, 0,      64, 127, 127,    127, -128, -128, 1, 2, 63, 1};
    vt[6] = '{"low_tie",   1, 0, -3,      40, 3, 0,        -1, 0, 0,        2, 0, 1, 9};

    rst = 1'b1; frame_start = 1'b0; res_valid = 1'b0; res_rel = '0; res_img = '0;
    repeat (3) tick();
    chk("rst_mag_valid", int'(mag_valid), 0);
    chk("rst_peak_valid", int'(peak_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mag_out", int'(mag_out), 0);
    chk("rst_peak_bin", int'(peak_bin), 0);
    chk("rst_peak_mag", int'(peak_mag), 0);
    rst = 1'b0;
    tick();

    // Directed spectra
    for (int v = 0; v < 7; v++) begin
      clear_frame();
      if (vt[v].b0 >= 0) begin fr_re[vt[v].b0] = vt[v].r0; fr_im[vt[v].b0] = vt[v].i0; end
      if (vt[v].b1 >= 0) begin fr_re[vt[v].b1] = vt[v].r1; fr_im[vt[v].b1] = vt[v].i1; end
      if (vt[v].b2 >= 0) begin fr_re[vt[v].b2] = vt[v].r2; fr_im[vt[v].b2] = vt[v].i2; end
      mq.delete(); pq.delete();
      drive_frame(vt[v].gap, NP, vt[v].extra, 1'b0, 6);
      check_frame(vt[v].name, vt[v].exp_bin, vt[v].exp_mag);
    end

    // Abort after 60 bins; strong old bins must not leak into the restarted search
    mq.delete(); pq.delete();
    clear_frame();
    fr_re[2] = 127;  fr_im[2] = 127;
    fr_re[58] = 127; fr_im[58] = 127;
    fr_re[59] = 127; fr_im[59] = 127;
    drive_frame(1, 60, 0, 1'b0, 0);
    clear_frame();
    fr_re[0] = 10;  fr_im[0] = 10;
    fr_re[7] = 50;  fr_im[7] = 50;
    fr_re[8] = -50; fr_im[8] = 50;
    drive_frame(1, NP, 0, 1'b1, 6);
    chk("abort_mag_count", mq.size(), 60 + NP);
    if (mq.size() > 60) begin
      chk("abort_bin0_index", mq[60].bin, 0);
      chk("abort_bin0_mag", mq[60].mag, 200);
      chk("abort_bin0_cycle", mq[60].cyc, drv_cyc[0] + 2);
    end
    chk("abort_peak_count", pq.size(), 1);
    if (pq.size() > 0) chk("abort_peak_cycle", pq[0].cyc, drv_cyc[NP-1] + 3);
    chk("abort_peak_bin", int'(peak_bin), 7);
    chk("abort_peak_mag", int'(peak_mag), 5000);

    // Reset after 40 bins, then stray res_valid with no frame_start
    clear_frame();
    for (int i = 0; i < 40; i++) begin
      fr_re[i] = int'($urandom_range(100, 20));
      fr_im[i] = -int'($urandom_range(100, 20));
    end
    drive_frame(1, 40, 0, 1'b0, 0);
    rst = 1'b1; res_valid = 1'b1; res_rel = 8'd77; res_img = 8'd33;
    tick();
    chk("mrst_mag_valid", int'(mag_valid), 0);
    chk("mrst_peak_valid", int'(peak_valid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_mag_out", int'(mag_out), 0);
    chk("mrst_mag_bin", int'(mag_bin), 0);
    chk("mrst_peak_bin", int'(peak_bin), 0);
    chk("mrst_peak_mag", int'(peak_mag), 0);
    rst = 1'b0;
    mq.delete(); pq.delete();
    for (int i = 0; i < 20; i++) begin
      res_valid = 1'b1;
      res_rel = 8'($urandom_range(255));
      res_img = 8'($urandom_range(255));
      tick();
    end
    res_valid = 1'b0;
    repeat (5) tick();
    chk("idle_mag_count", mq.size(), 0);
    chk("idle_peak_count", pq.size(), 0);
    chk("idle_busy", int'(busy), 0);

    // Random frames against the reference model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NP; i++) begin
        case (r % 3)
          0: begin
            fr_re[i] = int'($urandom_range(6)) - 3;
            fr_im[i] = int'($urandom_range(6)) - 3;
          end
          1: begin
            fr_re[i] = int'($urandom_range(255)) - 128;
            fr_im[i] = int'($urandom_range(255)) - 128;
          end
          default: begin
            fr_re[i] = ($urandom_range(15) == 0) ? int'($urandom_range(255)) - 128 : 0;
            fr_im[i] = ($urandom_range(15) == 0) ? int'($urandom_range(255)) - 128 : 0;
          end
        endcase
      end
      model_peak(pb, pm);
      mq.delete(); pq.delete();
      drive_frame(0, NP, (r % 2) * 2, 1'b0, 6);
      check_frame($sformatf("rand%0d", r), pb, pm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
